// File: rtl/pipe_fetch_queue.sv
// -----------------------------------------------------------------------------
// pipe_fetch_queue
//
// Fetch-to-decode pipeline stage built as a small in-order instruction queue.
// Fetch (F) pushes {instruction, pc, pc+4} when the queue has room. Decode (D)
// consumes the head entry unless it is stalling. A taken branch or jump in D
// flushes every queued entry, including the one F is offering in that cycle.
// The head instruction's register-index fields are sliced out here, so the
// decoder can start register-file reads without doing its own field
// extraction.
//
// Parameters
//   ADDRESS_WIDTH  width of PC values
//   DATA_WIDTH     instruction width (RV32 encoding)
//   WRITE_WIDTH    register-index width
//   DEPTH          number of queue entries (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   validf     F presents an instruction this cycle
//   rd         instruction word from instruction memory
//   pcf        PC of that instruction
//   pcplus4f   pcf + 4
//   readyf     queue can accept an instruction (count < DEPTH)
//   stalld     D cannot consume the head this cycle
//   flushd     discard every queued instruction and the incoming one
//   validd     head entry is valid
//   instrd     head instruction (NOP when empty)
//   pcd        head PC (0 when empty)
//   pcplus4d   head PC + 4 (0 when empty)
//   rdd        instrd[11:7]
//   rs1d       instrd[19:15]
//   rs2d       instrd[24:20]
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module pipe_fetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WRITE_WIDTH   = 5,
  parameter int DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     validf,
  input  logic [DATA_WIDTH-1:0]    rd,
  input  logic [ADDRESS_WIDTH-1:0] pcf,
  input  logic [ADDRESS_WIDTH-1:0] pcplus4f,
  output logic                     readyf,
  input  logic                     stalld,
  input  logic                     flushd,
  output logic                     validd,
  output logic [DATA_WIDTH-1:0]    instrd,
  output logic [ADDRESS_WIDTH-1:0] pcd,
  output logic [ADDRESS_WIDTH-1:0] pcplus4d,
  output logic [WRITE_WIDTH-1:0]   rdd,
  output logic [WRITE_WIDTH-1:0]   rs1d,
  output logic [WRITE_WIDTH-1:0]   rs2d,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  // addi x0, x0, 0 -- what the decoder sees whenever the queue is empty
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013);

  // Queue storage
  logic [DATA_WIDTH-1:0]    instr_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    instr_d   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_q      [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_d      [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pcplus4_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pcplus4_d [DEPTH];

  // Pointers and occupancy
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;

  logic [DATA_WIDTH-1:0]    head_instr;
  logic [ADDRESS_WIDTH-1:0] head_pc;
  logic [ADDRESS_WIDTH-1:0] head_pcplus4;

  // Handshake status comes only from the registered count. Because of this,
  // a pop in the current cycle never opens a slot for a push in the same
  // cycle. The queue trades that throughput for a shorter
  // readyf -> PC-logic path.
  always_comb begin
    readyf = (count_q < FULL_COUNT);
    validd = (count_q != '0);
  end

  // A flush cancels both sides of the handshake. The wrong-path instruction
  // from F is dropped, and D does not consume the head.
  always_comb begin
    push = validf & readyf & ~flushd;
    pop  = validd & ~stalld & ~flushd;
  end

  // Next-state logic for the pointers, the count and the storage. Pointers
  // are exactly log2(DEPTH) bits wide, so they wrap from DEPTH-1 to 0 on
  // their own. Entries are not cleared on a flush because count alone
  // decides which entries are valid.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;

    if (flushd) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        instr_d[wptr_q]   = rd;
        pc_d[wptr_q]      = pcf;
        pcplus4_d[wptr_q] = pcplus4f;
        wptr_d            = wptr_q + PTR_ONE;
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. Reset clears the storage as well as the control state,
  // so the queue always starts from a known image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i]   <= '0;
        pc_q[i]      <= '0;
        pcplus4_q[i] <= '0;
      end
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  // Head read. No bypass path exists from F, so an instruction pushed in
  // this cycle first shows up here after the next clock edge.
  always_comb begin
    head_instr   = instr_q[rptr_q];
    head_pc      = pc_q[rptr_q];
    head_pcplus4 = pcplus4_q[rptr_q];
  end

  // Decode-facing outputs. When the queue is empty they show a clean NOP,
  // so stale storage never leaks into decode.
  always_comb begin
    instrd   = validd ? head_instr   : NOP_INSTR;
    pcd      = validd ? head_pc      : '0;
    pcplus4d = validd ? head_pcplus4 : '0;
    count    = count_q;
  end

  // Register-index fields come from the driven instrd, not from the raw
  // storage. When the queue is empty they read as the NOP's fields (all 0).
  always_comb begin
    rdd  = WRITE_WIDTH'(instrd[11:7]);
    rs1d = WRITE_WIDTH'(instrd[19:15]);
    rs2d = WRITE_WIDTH'(instrd[24:20]);
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_pipe_fetch_queue
//
// Testbench for pipe_fetch_queue. A DEPTH=2 instance runs a table of
// single-cycle vectors covering fill/drain, streaming, flush and
// full-with-pop, followed by a mid-cycle reset sequence. A DEPTH=4 instance
// runs a hand-written sequence that wraps the pointers, checked against a
// small ordered model.
// -----------------------------------------------------------------------------
module tb_pipe_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  // DEPTH=2 instance signals
  logic        validf2, stalld2, flushd2;
  logic [31:0] rd2, pcf2, pcplus4f2;
  logic        readyf2, validd2;
  logic [31:0] instrd2, pcd2, pcplus4d2;
  logic [4:0]  rdd2, rs1d2, rs2d2;
  logic [1:0]  count2;

  // DEPTH=4 instance signals
  logic        validf4, stalld4, flushd4;
  logic [31:0] rd4, pcf4, pcplus4f4;
  logic        readyf4, validd4;
  logic [31:0] instrd4, pcd4, pcplus4d4;
  logic [4:0]  rdd4, rs1d4, rs2d4;
  logic [2:0]  count4;

  int error_count = 0;
  int check_count = 0;

  pipe_fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WRITE_WIDTH(5), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .validf(validf2), .rd(rd2), .pcf(pcf2), .pcplus4f(pcplus4f2),
    .readyf(readyf2), .stalld(stalld2), .flushd(flushd2), .validd(validd2), .instrd(instrd2),
    .pcd(pcd2), .pcplus4d(pcplus4d2), .rdd(rdd2), .rs1d(rs1d2), .rs2d(rs2d2), .count(count2)
  );

  pipe_fetch_queue #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WRITE_WIDTH(5), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .validf(validf4), .rd(rd4), .pcf(pcf4), .pcplus4f(pcplus4f4),
    .readyf(readyf4), .stalld(stalld4), .flushd(flushd4), .validd(validd4), .instrd(instrd4),
    .pcd(pcd4), .pcplus4d(pcplus4d4), .rdd(rdd4), .rs1d(rs1d4), .rs2d(rs2d4), .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: inputs for this cycle plus the outputs expected before the edge
  typedef struct {
    logic        validf;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        stalld;
    logic        flushd;
    logic        exp_validd;
    logic        exp_readyf;
    int          exp_count;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcd;
  } vec_t;

  vec_t vecs [23];

  // Counts one comparison and prints a line if it does not match
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Checks every output of the DEPTH=2 instance against the expected head state
  task automatic checkHead2(input string tag, input logic exp_valid, input logic exp_ready,
                            input int exp_cnt, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
    logic [31:0] ei;
    logic [31:0] ep4;
    ei  = exp_instr;
    ep4 = exp_valid ? exp_pc + 32'd4 : 32'd0;
    checkOutput({tag, ".validd"},   32'(validd2),   32'(exp_valid));
    checkOutput({tag, ".readyf"},   32'(readyf2),   32'(exp_ready));
    checkOutput({tag, ".count"},    32'(count2),    32'(exp_cnt));
    checkOutput({tag, ".instrd"},   instrd2,        ei);
    checkOutput({tag, ".pcd"},      pcd2,           exp_pc);
    checkOutput({tag, ".pcplus4d"}, pcplus4d2,      ep4);
    checkOutput({tag, ".rdd"},      32'(rdd2),      32'(ei[11:7]));
    checkOutput({tag, ".rs1d"},     32'(rs1d2),     32'(ei[19:15]));
    checkOutput({tag, ".rs2d"},     32'(rs2d2),     32'(ei[24:20]));
  endtask

  // Drives one vector onto the DEPTH=2 instance
  task automatic applyStimulus(input vec_t v);
    validf2   = v.validf;
    rd2       = v.instr;
    pcf2      = v.pc;
    pcplus4f2 = v.pc + 32'd4;
    stalld2   = v.stalld;
    flushd2   = v.flushd;
  endtask

  // Instruction word tied to a PC, for the DEPTH=4 ordering checks
  function automatic logic [31:0] mkInstr(input logic [31:0] pc);
    return (pc * 32'h0101_0101) ^ 32'h0020_81B3;
  endfunction

  logic [31:0] exp_q [$];

  // Pushes one entry into the DEPTH=4 instance while D stalls
  task automatic push4(input logic [31:0] pc);
    validf4   = 1'b1;
    rd4       = mkInstr(pc);
    pcf4      = pc;
    pcplus4f4 = pc + 32'd4;
    stalld4   = 1'b1;
    #1;
    checkOutput($sformatf("wrap.push%0h.readyf", pc), 32'(readyf4), 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(pc);
    validf4 = 1'b0;
  endtask

  // Pops the head of the DEPTH=4 instance and checks it against the model.
  // With offer=1, F also presents an instruction, which a full queue must drop.
  task automatic pop4(input logic offer);
    logic [31:0] ei;
    logic [31:0] epc;
    epc       = (exp_q.size() != 0) ? exp_q[0] : 32'hFFFF_FFFF;
    ei        = mkInstr(epc);
    validf4   = offer;
    rd4       = mkInstr(32'h0000_0DE0);
    pcf4      = 32'h0000_0DE0;
    pcplus4f4 = 32'h0000_0DE4;
    stalld4   = 1'b0;
    #1;
    checkOutput($sformatf("wrap.pop%0h.validd", epc), 32'(validd4), 32'd1);
    checkOutput($sformatf("wrap.pop%0h.pcd", epc), pcd4, epc);
    checkOutput($sformatf("wrap.pop%0h.pcplus4d", epc), pcplus4d4, epc + 32'd4);
    checkOutput($sformatf("wrap.pop%0h.instrd", epc), instrd4, ei);
    checkOutput($sformatf("wrap.pop%0h.rdd", epc), 32'(rdd4), 32'(ei[11:7]));
    checkOutput($sformatf("wrap.pop%0h.rs1d", epc), 32'(rs1d4), 32'(ei[19:15]));
    checkOutput($sformatf("wrap.pop%0h.rs2d", epc), 32'(rs2d4), 32'(ei[24:20]));
    if (offer) checkOutput("wrap.fullpop.readyf", 32'(readyf4), 32'd0);
    @(posedge clk); #1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    validf4 = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    validf2 = 1'b0; rd2 = '0; pcf2 = '0; pcplus4f2 = '0; stalld2 = 1'b0; flushd2 = 1'b0;
    validf4 = 1'b0; rd4 = '0; pcf4 = '0; pcplus4f4 = '0; stalld4 = 1'b0; flushd4 = 1'b0;

    //            validf instr          pc        stall flush  v  r  cnt  exp_instr      exp_pcd
    vecs[0]  = '{1'b1, 32'h00500093, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[1]  = '{1'b1, 32'h00A00113, 32'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h00500093, 32'h00};
    vecs[2]  = '{1'b1, 32'h00F00193, 32'h08, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h00500093, 32'h00};
    vecs[3]  = '{1'b0, 32'h0,        32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2, 32'h00500093, 32'h00};
    vecs[4]  = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h00500093, 32'h00};
    vecs[5]  = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h00A00113, 32'h04};
    vecs[6]  = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[7]  = '{1'b1, 32'h002081B3, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[8]  = '{1'b1, 32'h40418233, 32'h14, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h002081B3, 32'h10};
    vecs[9]  = '{1'b1, 32'h0062A023, 32'h18, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h40418233, 32'h14};
    vecs[10] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h0062A023, 32'h18};
    vecs[11] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[12] = '{1'b1, 32'h00C58593, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[13] = '{1'b1, 32'hFE5FF06F, 32'h24, 1'b0, 1'b1, 1'b1, 1'b1, 1, 32'h00C58593, 32'h20};
    vecs[14] = '{1'b1, 32'h01F00F93, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[15] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h01F00F93, 32'h40};
    vecs[16] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[17] = '{1'b1, 32'h00730313, 32'h50, 1'b1, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};
    vecs[18] = '{1'b1, 32'h00838393, 32'h54, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h00730313, 32'h50};
    vecs[19] = '{1'b1, 32'h00940413, 32'h58, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h00730313, 32'h50};
    vecs[20] = '{1'b0, 32'h0,        32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h00838393, 32'h54};
    vecs[21] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h00838393, 32'h54};
    vecs[22] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, NOP,          32'h00};

    // Power-on reset state
    #12;
    checkHead2("reset", 1'b0, 1'b1, 0, NOP, 32'h0);
    checkOutput("reset4.count", 32'(count4), 32'd0);
    checkOutput("reset4.readyf", 32'(readyf4), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single-cycle vectors on the DEPTH=2 instance
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkHead2($sformatf("v%0d", i), vecs[i].exp_validd, vecs[i].exp_readyf,
                 vecs[i].exp_count, vecs[i].exp_instr, vecs[i].exp_pcd);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-cycle with a full queue
    applyStimulus('{1'b1, 32'h00100093, 32'h60, 1'b1, 1'b0, 1'b0, 1'b0, 0, NOP, 32'h0});
    @(posedge clk); #1;
    applyStimulus('{1'b1, 32'h00200113, 32'h64, 1'b1, 1'b0, 1'b0, 1'b0, 0, NOP, 32'h0});
    @(posedge clk); #1;
    applyStimulus('{1'b1, 32'h00300193, 32'h70, 1'b1, 1'b0, 1'b0, 1'b0, 0, NOP, 32'h0});
    #1;
    checkHead2("prereset", 1'b1, 1'b0, 2, 32'h00100093, 32'h60);
    #2;
    rst_n = 1'b0;
    #1;
    checkHead2("midreset", 1'b0, 1'b1, 0, NOP, 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkHead2("postreset", 1'b1, 1'b1, 1, 32'h00300193, 32'h70);
    validf2 = 1'b0;
    stalld2 = 1'b0;
    @(posedge clk); #1;
    checkHead2("postreset.drain", 1'b0, 1'b1, 0, NOP, 32'h0);

    // Pointer wrap on DEPTH=4: push 3, pop 2, push 3, pop 4
    push4(32'h100); push4(32'h104); push4(32'h108);
    checkOutput("wrap.count3", 32'(count4), 32'd3);
    pop4(1'b0); pop4(1'b0);
    checkOutput("wrap.count1", 32'(count4), 32'd1);
    push4(32'h10C); push4(32'h110); push4(32'h114);
    checkOutput("wrap.full.count", 32'(count4), 32'd4);
    checkOutput("wrap.full.readyf", 32'(readyf4), 32'd0);
    pop4(1'b1);
    checkOutput("wrap.fullpop.count", 32'(count4), 32'd3);
    checkOutput("wrap.fullpop.readyf_after", 32'(readyf4), 32'd1);
    pop4(1'b0); pop4(1'b0); pop4(1'b0);
    checkOutput("wrap.end.count", 32'(count4), 32'd0);
    checkOutput("wrap.end.validd", 32'(validd4), 32'd0);
    checkOutput("wrap.end.instrd", instrd4, NOP);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
